// File: rtl/int_pkg.sv
// int_pkg: shared cause codes, FSM state encoding and default widths for the
// interrupt dispatch controller.
package int_pkg;
   localparam int ADDR_W_DEF = 16;
   typedef enum logic [1:0] {
      CAUSE_NONE  = 2'b00,
      CAUSE_SYS   = 2'b01,
      CAUSE_DMA   = 2'b10,
      CAUSE_TIMER = 2'b11
   } cause_e;
   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      TAKE    = 2'b01,
      SERVICE = 2'b10
   } state_e;
endpackage

// File: rtl/int_prio_enc.sv
// int_prio_enc: fixed-priority encoder, i_req = {timer, dma, syscall}; syscall wins.
module int_prio_enc
   import int_pkg::*;
(
   input  logic [2:0] i_req,
   output logic [1:0] o_cause,
   output logic [2:0] o_grant
);
   always_comb begin
      o_grant = i_req[0] ? 3'b001 : i_req[1] ? 3'b010 : i_req[2] ? 3'b100 : 3'b000;
      o_cause = i_req[0] ? CAUSE_SYS : i_req[1] ? CAUSE_DMA : i_req[2] ? CAUSE_TIMER : CAUSE_NONE;
   end
endmodule

// File: rtl/int_dispatch_ctrl.sv
// int_dispatch_ctrl: latches syscall/DMA/timer requests, arbitrates them and
// redirects fetch at a user-mode instruction boundary, holding service until iret.
module int_dispatch_ctrl
   import int_pkg::*;
#(
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int DMA_CNT_W = 3
) (
   input  logic                 clock,
   input  logic                 init_flag,
   input  logic                 inst_boundary,
   input  logic [ADDR_W-1:0]    pc,
   input  logic [15:0]          r_k,
   input  logic                 timer_int,
   input  logic                 dma_op_ready,
   input  logic                 syscall_req,
   input  logic                 iret,
   input  logic [ADDR_W-1:0]    timer_int_pos,
   input  logic [ADDR_W-1:0]    op_int_pos,
   input  logic [ADDR_W-1:0]    sys_int_pos,
   output logic                 int_take,
   output logic [ADDR_W-1:0]    int_pos,
   output logic [1:0]           int_cause,
   output logic [ADDR_W-1:0]    epc,
   output logic                 in_service,
   output logic                 timer_reset_req,
   output logic [DMA_CNT_W-1:0] dma_pending,
   output logic [1:0]           err_flags
);
   state_e                r_state, w_next;
   logic                  r_sys_pend;
   logic [DMA_CNT_W-1:0]  r_dma_cnt;
   logic [ADDR_W-1:0]     r_pos, r_epc;
   logic [1:0]            r_cause, r_err;
   logic                  w_sys, w_dma, w_go, w_inc, w_dec, w_max;
   logic [1:0]            w_cause;
   logic [2:0]            w_grant;
   logic [ADDR_W-1:0]     w_vec;

   // a request arriving on the deciding edge counts, so take follows one cycle later
   assign w_sys = r_sys_pend | syscall_req;
   assign w_dma = (r_dma_cnt != '0) | dma_op_ready;

   int_prio_enc u_prio (
      .i_req   ({timer_int, w_dma, w_sys}),
      .o_cause (w_cause),
      .o_grant (w_grant)
   );

   always_comb begin
      w_go   = (r_state == IDLE) && (w_sys || w_dma || timer_int) && inst_boundary && (r_k == '0);
      w_vec  = w_grant[0] ? sys_int_pos : w_grant[1] ? op_int_pos : timer_int_pos;
      w_inc  = dma_op_ready;
      w_dec  = (r_state == TAKE) && (r_cause == CAUSE_DMA);
      w_max  = &r_dma_cnt;
      w_next = (r_state == IDLE) ? (w_go ? TAKE : IDLE) :
               (r_state == TAKE) ? SERVICE :
               (iret ? IDLE : SERVICE);
   end

   always_ff @(posedge clock or negedge init_flag) begin
      if (!init_flag) begin
         r_state    <= IDLE;
         r_sys_pend <= 1'b0;
         r_dma_cnt  <= '0;
         r_pos      <= '0;
         r_epc      <= '0;
         r_cause    <= CAUSE_NONE;
         r_err      <= '0;
      end else begin
         r_state <= w_next;
         if (w_go) begin
            r_pos   <= w_vec;
            r_cause <= w_cause;
            r_epc   <= pc;
         end
         if ((r_state == IDLE) && syscall_req)
            r_sys_pend <= 1'b1;
         else if ((r_state == TAKE) && (r_cause == CAUSE_SYS))
            r_sys_pend <= 1'b0;
         if (w_inc && !w_dec && !w_max)
            r_dma_cnt <= r_dma_cnt + DMA_CNT_W'(1);
         else if (w_dec && !w_inc)
            r_dma_cnt <= r_dma_cnt - DMA_CNT_W'(1);
         if (w_inc && !w_dec && w_max)
            r_err[0] <= 1'b1;
         if ((r_state != IDLE) && syscall_req)
            r_err[1] <= 1'b1;
      end
   end

   assign int_take        = (r_state == TAKE);
   assign in_service      = (r_state != IDLE);
   assign timer_reset_req = (r_state == TAKE) && (r_cause == CAUSE_TIMER);
   assign int_pos         = r_pos;
   assign int_cause       = r_cause;
   assign epc             = r_epc;
   assign dma_pending     = r_dma_cnt;
   assign err_flags       = r_err;
endmodule

// File: doc/int_dispatch_ctrl.md
Name: int_dispatch_ctrl

Overview:
Interrupt dispatch controller between the scheduler's interrupt sources (timer, DMA completion, syscall) and the CPU fetch stage. It latches pending requests and arbitrates them by fixed priority. At an instruction boundary in user mode it issues a one-cycle take pulse with jump vector, cause code and saved return PC. It then holds service state until the kernel executes a return-from-interrupt.

Parameters:
ADDR_W, 16, width of PC and vector positions
DMA_CNT_W, 3, width of saturating pending-DMA-completion counter (max 2^DMA_CNT_W-1)

Ports:
clock  in  1  system clock, all state on posedge
init_flag  in  1  asynchronous active-low reset; 0 clears all state immediately
inst_boundary  in  1  CPU is at an instruction boundary and may be redirected this cycle
pc  in  ADDR_W  PC of next instruction (return address)
r_k  in  16  kernel-mode register; nonzero = kernel mode
timer_int  in  1  level timer interrupt from scheduler
dma_op_ready  in  1  one-cycle pulse per completed DMA operation
syscall_req  in  1  one-cycle pulse from decoder on SYSCALL
iret  in  1  one-cycle pulse on return-from-interrupt
timer_int_pos  in  ADDR_W  timer vector
op_int_pos  in  ADDR_W  DMA vector
sys_int_pos  in  ADDR_W  syscall vector
int_take  out  1  one-cycle redirect pulse to fetch
int_pos  out  ADDR_W  jump target, valid with int_take and held until next take
int_cause  out  2  00 none, 01 syscall, 10 DMA, 11 timer
epc  out  ADDR_W  saved return PC
in_service  out  1  high from take until iret
timer_reset_req  out  1  one-cycle pulse to scheduler reset_timer config path
dma_pending  out  DMA_CNT_W  pending DMA completions
err_flags  out  2  sticky: [0] DMA counter overflow, [1] syscall while in service

Behaviour:
- Reset (init_flag=0, async): FSM=IDLE; all outputs 0; pending syscall flag and DMA counter cleared. Applies mid-service: in_service drops at once with no iret needed.
- Pending sources:
  - sys_pend sets on syscall_req and clears when syscall is taken.
  - DMA counter increments on dma_op_ready and decrements on DMA take. Simultaneous increment and decrement leaves it unchanged. Increment at max saturates and sets err_flags[0].
  - timer_int is used as a level and is not latched.
- Priority: syscall > DMA > timer.
- FSM states IDLE, TAKE, SERVICE.
  - IDLE -> TAKE when any source is pending, inst_boundary=1 and r_k==0. The winner is registered at this edge: int_pos/int_cause from the winner's vector, epc<=pc.
  - TAKE lasts exactly 1 cycle with int_take=1. The winning source's pending is consumed. If cause=timer, timer_reset_req=1 in the same cycle. Then -> SERVICE.
  - SERVICE: in_service=1. Stays until iret=1, then -> IDLE. A new take is possible no earlier than 1 cycle after return to IDLE.
- Latency: a source pending at edge N with boundary/user conditions met gives int_take high in cycle N+1.
- Boundary cases:
  - In kernel mode (r_k!=0) or without inst_boundary, nothing is taken and all pending is held.
  - syscall_req during TAKE/SERVICE is not latched and sets err_flags[1].
  - dma_op_ready during TAKE/SERVICE is counted.
  - iret in IDLE or TAKE is ignored.
  - A vector change after take does not alter the held int_pos.
  - A timer level that drops before the take cycle is lost; this is correct.
- Outputs are registered; no combinational input-to-output paths except none.

Decomposition:
- Shared package int_pkg: cause encodings (CAUSE_NONE/SYS/DMA/TIMER), FSM state encodings, ADDR_W default.
- One natural sub-module, int_prio_enc: combinational 3-input fixed-priority encoder producing the cause code and a one-hot grant.

Test Plan:
- Reset with DMA count 3 and in SERVICE: init_flag=0 -> in_service=0, dma_pending=0, int_cause=00 same cycle.
- sys_int_pos=0x0100, syscall_req pulse, inst_boundary=1, r_k=0, pc=0x0042 -> next cycle int_take=1, int_pos=0x0100, int_cause=01, epc=0x0042. Then iret -> in_service=0.
- timer_int=1, dma_op_ready and syscall_req in the same cycle -> takes in order syscall, DMA, timer across three take/iret rounds. The timer take has timer_reset_req=1 and int_pos=timer_int_pos.
- r_k=1, dma_op_ready x2 -> no int_take, dma_pending=2. Set r_k=0 -> DMA take, dma_pending=1.
- Eight dma_op_ready pulses in kernel mode -> dma_pending=7, err_flags[0]=1. syscall_req in SERVICE -> err_flags[1]=1, no new take.
- dma_op_ready coincident with DMA take cycle, count=2 -> count stays 2. iret while IDLE -> no state change.
